// File: rtl/led_seq_pkg.sv
// -----------------------------------------------------------------------------
// led_seq_pkg : mode and state encodings shared by the LED pattern sequencer
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package led_seq_pkg;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_FILL   = 2'd1;
  localparam logic [1:0] MODE_ALT    = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  function automatic logic [1:0] next_mode(input logic [1:0] mode);
    return (mode == MODE_ALT) ? MODE_SINGLE : mode + 2'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce : 2-FF synchroniser, stable-level counter, rising-edge press pulse
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module btn_debounce #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic resetn,
  input  logic btn_i,
  output logic press_o
);

  localparam int             CW       = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      // Any sample that agrees with the current level restarts the stability window
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sync2_q;
        press_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign press_o = press_q;

endmodule

`default_nettype wire

// File: rtl/led_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// led_pattern_sequencer : debounced front-panel buttons drive a prescaled LED shift-chain FSM
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int N_LED     = 10,
  parameter int TICK_DIV  = 5_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_btn_start,
  input  logic             i_btn_mode,
  input  logic             i_btn_stop,
  output logic [N_LED-1:0] o_led,
  output logic [1:0]       o_mode,
  output logic             o_busy
);

  localparam int            PW        = $clog2(TICK_DIV);
  localparam int            SW        = $clog2(2 * N_LED) + 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STEP_MAX  = '1;
  localparam logic [SW-1:0] FILL_LAST = SW'(N_LED - 1);

  logic start_p, mode_p, stop_p;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
    .clk(clk), .resetn(resetn), .btn_i(i_btn_start), .press_o(start_p));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
    .clk(clk), .resetn(resetn), .btn_i(i_btn_mode), .press_o(mode_p));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_stop (
    .clk(clk), .resetn(resetn), .btn_i(i_btn_stop), .press_o(stop_p));

  state_e           state_q;
  logic [PW-1:0]    pre_q;
  logic [SW-1:0]    step_q;
  logic [N_LED-1:0] led_q;
  logic [1:0]       mode_q;
  logic             busy_q;

  logic stop_ev, start_ev, mode_ev;
  logic tick, din, last_bit;

  // A stop pulse swallows any start/mode pulse of the same cycle
  assign stop_ev  = stop_p;
  assign start_ev = start_p & ~stop_p;
  assign mode_ev  = mode_p & ~stop_p & ~start_p;

  assign tick = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && (pre_q == PRE_LAST);

  always_comb begin
    din      = 1'b0;
    last_bit = 1'b0;
    if (state_q == ST_RUN) begin
      case (mode_q)
        MODE_SINGLE: begin
          din      = (step_q == '0);
          last_bit = (step_q == '0);
        end
        MODE_FILL: begin
          din      = (step_q < SW'(N_LED));
          last_bit = (step_q == FILL_LAST);
        end
        default: din = ~step_q[0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      step_q  <= '0;
      led_q   <= '0;
      mode_q  <= MODE_SINGLE;
      busy_q  <= 1'b0;
    end else begin
      if (tick) begin
        led_q <= {led_q[N_LED-2:0], din};
      end
      case (state_q)
        ST_IDLE: begin
          if (start_ev) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            pre_q   <= '0;
            step_q  <= '0;
          end else if (mode_ev) begin
            mode_q <= next_mode(mode_q);
          end
        end
        ST_RUN: begin
          pre_q <= tick ? '0 : pre_q + PW'(1);
          if (tick && (step_q != STEP_MAX)) begin
            step_q <= step_q + SW'(1);
          end
          // Pattern completion outranks a simultaneous pause request
          if (stop_ev || (tick && last_bit)) begin
            state_q <= ST_DRAIN;
          end else if (start_ev) begin
            state_q <= ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (stop_ev) begin
            state_q <= ST_DRAIN;
          end else if (start_ev) begin
            state_q <= ST_RUN;
          end
        end
        ST_DRAIN: begin
          pre_q <= tick ? '0 : pre_q + PW'(1);
          if (led_q == '0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_led  = led_q;
  assign o_mode = mode_q;
  assign o_busy = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_sequencer : vector table, directed corner sequences and random buttons vs. model
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_led_pattern_sequencer;

  localparam int N  = 10;
  localparam int TD = 4;
  localparam int DB = 3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic         clk = 1'b0;
  logic         resetn = 1'b1;
  logic         btn_start = 1'b0;
  logic         btn_mode = 1'b0;
  logic         btn_stop = 1'b0;
  logic [N-1:0] o_led;
  logic [1:0]   o_mode;
  logic         o_busy;

  int n_vec  = 0;
  int n_fail = 0;

  led_pattern_sequencer #(.N_LED(N), .TICK_DIV(TD), .DB_CYCLES(DB)) dut (
    .clk(clk), .resetn(resetn),
    .i_btn_start(btn_start), .i_btn_mode(btn_mode), .i_btn_stop(btn_stop),
    .o_led(o_led), .o_mode(o_mode), .o_busy(o_busy));

  always #5 clk = ~clk;

  // Reference model: button histories, pattern rules by step index, LED bar as a shifted word
  typedef struct packed {
    logic [1:0]       st;
    int               cnt;
    int               step;
    int               ticks;
    logic [N-1:0]     led;
    logic [1:0]       mode;
    logic [2:0]       lvl;
    logic [2:0]       pulse;
    logic [2:0][15:0] h;
  } mstate_t;

  mstate_t m;

  function automatic bit pattern_bit(input int mode, input int k);
    case (mode)
      0:       return k == 0;
      1:       return k < N;
      default: return (k % 2) == 0;
    endcase
  endfunction

  // Number of pattern bits before completion; 0 means the pattern never ends
  function automatic int pattern_len(input int mode);
    case (mode)
      0:       return 1;
      1:       return N;
      default: return 0;
    endcase
  endfunction

  function automatic mstate_t model_next(input mstate_t c, input logic [2:0] raw);
    mstate_t n;
    bit stop, start, mode_ev, tick, done, b_in;
    n       = c;
    stop    = c.pulse[2];
    start   = c.pulse[0] && !stop;
    mode_ev = c.pulse[1] && !stop && !c.pulse[0];
    tick    = ((c.st == S_RUN) || (c.st == S_DRAIN)) && (c.cnt == TD - 1);
    b_in    = (c.st == S_RUN) && pattern_bit(int'(c.mode), c.step);
    done    = (c.st == S_RUN) && tick && (pattern_len(int'(c.mode)) == c.step + 1);
    if (tick) begin
      n.led   = {c.led[N-2:0], b_in};
      n.ticks = c.ticks + 1;
    end
    if ((c.st == S_RUN) || (c.st == S_DRAIN)) n.cnt = tick ? 0 : c.cnt + 1;
    if ((c.st == S_RUN) && tick && (c.step < 63)) n.step = c.step + 1;
    case (c.st)
      S_IDLE: begin
        if (start) begin
          n.st = S_RUN; n.cnt = 0; n.step = 0;
        end else if (mode_ev) begin
          n.mode = (c.mode == 2'd2) ? 2'd0 : c.mode + 2'd1;
        end
      end
      S_RUN:   if (stop || done) n.st = S_DRAIN; else if (start) n.st = S_PAUSE;
      S_PAUSE: if (stop) n.st = S_DRAIN; else if (start) n.st = S_RUN;
      default: if (c.led == '0) n.st = S_IDLE;
    endcase
    // Level flips once the DB samples seen through the synchroniser all disagree with it
    for (int b = 0; b < 3; b++) begin
      n.pulse[b] = 1'b0;
      if (c.h[b][DB:1] == {DB{~c.lvl[b]}}) begin
        n.lvl[b]   = ~c.lvl[b];
        n.pulse[b] = ~c.lvl[b];
      end
      n.h[b] = {c.h[b][14:0], raw[b]};
    end
    return n;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) m <= '0;
    else         m <= model_next(m, {btn_stop, btn_mode, btn_start});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) begin
      @(negedge clk);
      chk("model", 32'({o_led, o_mode, o_busy}), 32'({m.led, m.mode, (m.st != S_IDLE)}));
    end
  endtask

  task automatic do_reset();
    {btn_stop, btn_mode, btn_start} = 3'b000;
    resetn = 1'b0;
    #1;
    chk("reset_state", 32'({o_led, o_mode, o_busy}), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic press_mode(input int k);
    repeat (k) begin
      btn_mode = 1'b1; cyc(6);
      btn_mode = 1'b0; cyc(8);
    end
  endtask

  task automatic start_run();
    btn_start = 1'b1; cyc(6);
    btn_start = 1'b0;
  endtask

  task automatic wait_ticks(input int target);
    int i;
    i = 0;
    while ((m.ticks < target) && (i < 400)) begin
      cyc(1);
      i++;
    end
    if (m.ticks < target) begin
      n_vec++;
      n_fail++;
      $display("FAIL tick_wait: got %0d ticks, want %0d", m.ticks, target);
    end
  endtask

  typedef struct {
    string      name;
    int         modes;
    int         ticks;
    logic [9:0] led;
    logic [1:0] mode;
    logic       busy;
  } vec_t;

  function automatic vec_t mk(input string nm, input int md, input int tk,
                              input logic [9:0] led, input logic [1:0] mo, input logic bz);
    vec_t v;
    v.name = nm; v.modes = md; v.ticks = tk; v.led = led; v.mode = mo; v.busy = bz;
    return v;
  endfunction

  vec_t tv[12];
  int   hold[3];

  initial begin
    tv[0]  = mk("alt_t1",     2, 1,  10'h001, 2'd2, 1'b1);
    tv[1]  = mk("alt_t2",     2, 2,  10'h002, 2'd2, 1'b1);
    tv[2]  = mk("alt_t3",     2, 3,  10'h005, 2'd2, 1'b1);
    tv[3]  = mk("alt_t4",     2, 4,  10'h00A, 2'd2, 1'b1);
    tv[4]  = mk("alt_t11",    2, 11, 10'h155, 2'd2, 1'b1);
    tv[5]  = mk("fill_t3",    1, 3,  10'h007, 2'd1, 1'b1);
    tv[6]  = mk("fill_t10",   1, 10, 10'h3FF, 2'd1, 1'b1);
    tv[7]  = mk("fill_t12",   1, 12, 10'h3FC, 2'd1, 1'b1);
    tv[8]  = mk("fill_t20",   1, 20, 10'h000, 2'd1, 1'b1);
    tv[9]  = mk("single_t1",  0, 1,  10'h001, 2'd0, 1'b1);
    tv[10] = mk("single_t3",  0, 3,  10'h004, 2'd0, 1'b1);
    tv[11] = mk("single_t11", 0, 11, 10'h000, 2'd0, 1'b1);

    // Quiet idle after reset
    do_reset();
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      chk("idle_quiet", 32'({o_led, o_mode, o_busy}), 32'd0);
    end

    foreach (tv[i]) begin
      do_reset();
      press_mode(tv[i].modes);
      start_run();
      wait_ticks(tv[i].ticks);
      chk({tv[i].name, "_led"},  32'(o_led),  32'(tv[i].led));
      chk({tv[i].name, "_mode"}, 32'(o_mode), 32'(tv[i].mode));
      chk({tv[i].name, "_busy"}, 32'(o_busy), 32'(tv[i].busy));
    end

    // Pause in ALT: start press right after tick 3 lands after tick 4
    do_reset();
    press_mode(2);
    start_run();
    wait_ticks(3);
    btn_start = 1'b1; cyc(6);
    btn_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk("pause_hold_led", 32'(o_led), 32'h00A);
      chk("pause_hold_busy", 32'(o_busy), 32'd1);
    end
    btn_start = 1'b1; cyc(6);
    btn_start = 1'b0;
    wait_ticks(5);
    chk("resume_led", 32'(o_led), 32'h015);

    // Start and stop in the same cycle: drain wins, run ends in IDLE
    do_reset();
    press_mode(2);
    start_run();
    wait_ticks(2);
    {btn_stop, btn_start} = 2'b11; cyc(6);
    {btn_stop, btn_start} = 2'b00;
    for (int i = 0; (i < 200) && o_busy; i++) cyc(1);
    chk("ss_busy", 32'(o_busy), 32'd0);
    chk("ss_led", 32'(o_led), 32'd0);

    // Two-cycle glitches are not presses
    do_reset();
    btn_mode = 1'b1; cyc(2);
    btn_mode = 1'b0; cyc(10);
    chk("glitch_mode", 32'(o_mode), 32'd0);
    btn_start = 1'b1; cyc(2);
    btn_start = 1'b0; cyc(10);
    chk("glitch_busy", 32'(o_busy), 32'd0);

    // Asynchronous reset in the middle of a FILL run
    do_reset();
    press_mode(1);
    start_run();
    wait_ticks(5);
    chk("mid_fill_led", 32'(o_led), 32'h01F);
    #3 resetn = 1'b0;
    #1;
    chk("rst_mid_led",  32'(o_led),  32'd0);
    chk("rst_mid_busy", 32'(o_busy), 32'd0);
    chk("rst_mid_mode", 32'(o_mode), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    cyc(2);

    // Random button activity against the model
    do_reset();
    hold = '{0, 0, 0};
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 3; b++) begin
        if (hold[b] == 0) begin
          hold[b] = int'($urandom_range(1, 12));
          case (b)
            0:       btn_start = ($urandom_range(0, 2) == 0);
            1:       btn_mode  = ($urandom_range(0, 1) == 0);
            default: btn_stop  = ($urandom_range(0, 7) == 0);
          endcase
        end else begin
          hold[b]--;
        end
      end
      cyc(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1);
  end

endmodule

`default_nettype wire
